// File: rtl/lab3_mem_line_serializer.sv
// Line-to-word memory serializer: splits a cache line request into
// word requests and assembles the replies. Option: LAB3_MEM_SERIALIZER_PIPE_EN.
module lab3_mem_line_serializer #(
  parameter int p_words = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   lreq_val,
  output logic                   lreq_rdy,
  input  logic                   lreq_type,
  input  logic [31:0]            lreq_addr,
  input  logic [7:0]             lreq_opaque,
  input  logic [32*p_words-1:0]  lreq_data,
  output logic                   lresp_val,
  input  logic                   lresp_rdy,
  output logic                   lresp_type,
  output logic [7:0]             lresp_opaque,
  output logic [32*p_words-1:0]  lresp_data,
  output logic                   wreq_val,
  input  logic                   wreq_rdy,
  output logic                   wreq_type,
  output logic [31:0]            wreq_addr,
  output logic [31:0]            wreq_data,
  input  logic                   wresp_val,
  output logic                   wresp_rdy,
  input  logic [31:0]            wresp_data
);

  localparam int lw = 32 * p_words;
  localparam int cw = $clog2(p_words) + 1;
  localparam int iw = (p_words > 1) ? $clog2(p_words) : 1;
  localparam logic [31:0] amask = ~(32'(lw / 8) - 32'd1);
  localparam logic [cw-1:0] last = cw'(p_words - 1);
`ifdef LAB3_MEM_SERIALIZER_PIPE_EN
  localparam logic [cw-1:0] full = cw'(p_words);
`endif

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [cw-1:0]   req_cnt;
  logic [cw-1:0]   resp_cnt;
  logic            type_q;
  logic [7:0]      opq_q;
  logic [31:0]     base_q;
  logic [31:0]     wd_q [p_words];
  logic [31:0]     rd_q [p_words];
  logic [lw-1:0]   line;
  logic [iw-1:0]   req_idx;
  logic [iw-1:0]   resp_idx;
  logic            wreq_fire;
  logic            wresp_fire;

  assign req_idx  = req_cnt[iw-1:0];
  assign resp_idx = resp_cnt[iw-1:0];

  assign lreq_rdy  = !reset && (state == IDLE);
  assign lresp_val = !reset && (state == RESP);

`ifdef LAB3_MEM_SERIALIZER_PIPE_EN
  assign wreq_val  = !reset && (state == ISSUE)
                     && (req_cnt < full);
  assign wresp_rdy = !reset
                     && (state == ISSUE || state == WAIT)
                     && (resp_cnt < req_cnt);
`else
  assign wreq_val  = !reset && (state == ISSUE);
  assign wresp_rdy = !reset && (state == WAIT);
`endif

  assign wreq_fire  = wreq_val && wreq_rdy;
  assign wresp_fire = wresp_val && wresp_rdy;

  assign wreq_type = type_q;
  assign wreq_addr = base_q + 32'({req_cnt, 2'b00});
  assign wreq_data = type_q ? wd_q[req_idx] : 32'h0;

  assign lresp_type   = type_q;
  assign lresp_opaque = opq_q;
  assign lresp_data   = type_q ? '0 : line;

  // pack the read buffer into one line, word 0 in the low bits
  always_comb begin
    line = '0;
    for (int i = 0; i < p_words; i++)
      line[32*i +: 32] = rd_q[i];
  end

  // control FSM with captured request and response buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      req_cnt  <= '0;
      resp_cnt <= '0;
      type_q   <= 1'b0;
      opq_q    <= '0;
      base_q   <= '0;
      for (int i = 0; i < p_words; i++) begin
        wd_q[i] <= '0;
        rd_q[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (lreq_val) begin
            type_q   <= lreq_type;
            opq_q    <= lreq_opaque;
            base_q   <= lreq_addr & amask;
            req_cnt  <= '0;
            resp_cnt <= '0;
            for (int i = 0; i < p_words; i++)
              wd_q[i] <= lreq_data[32*i +: 32];
            state <= ISSUE;
          end
        end
`ifdef LAB3_MEM_SERIALIZER_PIPE_EN
        ISSUE, WAIT: begin
          if (wreq_fire)
            req_cnt <= req_cnt + cw'(1);
          if (wresp_fire) begin
            rd_q[resp_idx] <= wresp_data;
            resp_cnt <= resp_cnt + cw'(1);
          end
          if (wresp_fire && resp_cnt == last)
            state <= RESP;
          else if (wreq_fire && req_cnt == last)
            state <= WAIT;
        end
`else
        ISSUE: begin
          if (wreq_fire) begin
            req_cnt <= req_cnt + cw'(1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (wresp_fire) begin
            rd_q[resp_idx] <= wresp_data;
            resp_cnt <= resp_cnt + cw'(1);
            state <= (resp_cnt == last) ? RESP : ISSUE;
          end
        end
`endif
        RESP: begin
          if (lresp_rdy)
            state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab3_mem_line_serializer.sv
// Bench for lab3_mem_line_serializer: line table, memory model
// with scoreboards, stall and mid-transaction reset sequences.
module tb_lab3_mem_line_serializer;

`ifdef LAB3_MEM_SERIALIZER_PIPE_EN
  localparam int LAT = 6;
  localparam logic [31:0] MASK = 32'h0000_001E;
`else
  localparam int LAT = 9;
  localparam logic [31:0] MASK = 32'h0000_00AA;
`endif

  logic         clk;
  logic         reset;
  logic         lreq_val;
  logic         lreq_rdy;
  logic         lreq_type;
  logic [31:0]  lreq_addr;
  logic [7:0]   lreq_opaque;
  logic [127:0] lreq_data;
  logic         lresp_val;
  logic         lresp_rdy;
  logic         lresp_type;
  logic [7:0]   lresp_opaque;
  logic [127:0] lresp_data;
  logic         wreq_val;
  logic         wreq_rdy;
  logic         wreq_type;
  logic [31:0]  wreq_addr;
  logic [31:0]  wreq_data;
  logic         wresp_val;
  logic         wresp_rdy;
  logic [31:0]  wresp_data;

  lab3_mem_line_serializer #(.p_words(4)) dut (
    .clk(clk), .reset(reset),
    .lreq_val(lreq_val), .lreq_rdy(lreq_rdy),
    .lreq_type(lreq_type), .lreq_addr(lreq_addr),
    .lreq_opaque(lreq_opaque), .lreq_data(lreq_data),
    .lresp_val(lresp_val), .lresp_rdy(lresp_rdy),
    .lresp_type(lresp_type), .lresp_opaque(lresp_opaque),
    .lresp_data(lresp_data),
    .wreq_val(wreq_val), .wreq_rdy(wreq_rdy),
    .wreq_type(wreq_type), .wreq_addr(wreq_addr),
    .wreq_data(wreq_data),
    .wresp_val(wresp_val), .wresp_rdy(wresp_rdy),
    .wresp_data(wresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         typ;
    logic [31:0]  addr;
    logic [7:0]   opq;
    logic [127:0] wdata;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  int checks = 0;
  int errors = 0;

  logic [64:0]  exp_wreq [$];
  logic [136:0] exp_lresp [$];
  logic [31:0]  rq [$];
  logic [31:0]  mem [logic [31:0]];
  int           stall_left = 0;
  logic [1:0]   stall_word = 2'd0;
  logic [136:0] le;

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  // memory model: single-cycle replies, in order, optional stall
  initial begin : memory
    logic rst_s, qf, pf, t;
    logic [31:0] a, d;
    wreq_rdy = 1'b1;
    wresp_val = 1'b0;
    wresp_data = '0;
    mem[32'h1000] = 32'h11;
    mem[32'h1004] = 32'h22;
    mem[32'h1008] = 32'h33;
    mem[32'h100C] = 32'h44;
    forever begin
      @(negedge clk);
      rst_s = reset;
      qf = wreq_val && wreq_rdy;
      pf = wresp_val && wresp_rdy;
      t = wreq_type;
      a = wreq_addr;
      d = wreq_data;
      if (!rst_s && wreq_val) begin
        if (exp_wreq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wreq_unexpected actual %h required none", a);
        end else begin
          chk("wreq", {95'd0, t, a, d}, {95'd0, exp_wreq[0]});
          if (qf) void'(exp_wreq.pop_front());
        end
      end
      @(posedge clk);
      #1;
      if (rst_s) rq.delete();
      else begin
        if (pf) void'(rq.pop_front());
        if (qf) begin
          if (t) begin
            mem[a] = d;
            rq.push_back(32'h0);
          end else
            rq.push_back(mem.exists(a) ? mem[a] : 32'h0);
        end
      end
      wresp_val = rq.size() > 0;
      wresp_data = (rq.size() > 0) ? rq[0] : 32'h0;
      wreq_rdy = 1'b1;
      if (stall_left > 0 && wreq_val && wreq_addr[3:2] == stall_word) begin
        wreq_rdy = 1'b0;
        stall_left--;
      end
    end
  end

  // line response scoreboard
  always @(negedge clk) begin
    if (!reset && lresp_val && lresp_rdy) begin
      if (exp_lresp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lresp_unexpected actual %h required none",
                 lresp_opaque);
      end else begin
        le = exp_lresp.pop_front();
        chk("lresp", {23'd0, lresp_type, lresp_opaque, lresp_data},
            {23'd0, le});
      end
    end
  end

  task automatic do_line(input vec_t v, input bit chk_lat,
                         input int lstall);
    logic [31:0] base;
    logic [31:0] wmask;
    int n;
    @(posedge clk);
    #1;
    base = v.addr & 32'hFFFF_FFF0;
    for (int i = 0; i < 4; i++)
      exp_wreq.push_back({v.typ, base + 32'(4 * i),
                          v.typ ? v.wdata[32*i +: 32] : 32'h0});
    exp_lresp.push_back({v.typ, v.opq, v.exp});
    lresp_rdy = (lstall == 0);
    lreq_val = 1'b1;
    lreq_type = v.typ;
    lreq_addr = v.addr;
    lreq_opaque = v.opq;
    lreq_data = v.wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lreq_rdy && n < 50);
    chk("lreq_accept", {159'd0, lreq_rdy}, 160'd1);
    @(posedge clk);
    #1;
    lreq_val = 1'b0;
    n = 0;
    wmask = '0;
    do begin
      @(negedge clk);
      n++;
      if (wreq_val && n < 32) wmask[n] = 1'b1;
    end while (!lresp_val && n < 200);
    chk("lresp_timeout", {159'd0, lresp_val}, 160'd1);
    if (chk_lat) begin
      chk("latency", 160'(n), 160'(LAT));
      chk("wreq_pattern", {128'd0, wmask}, {128'd0, MASK});
    end
    for (int k = 0; k < lstall; k++) begin
      if (k > 0) @(negedge clk);
      chk("lresp_hold", {158'd0, lresp_val, lreq_rdy}, 160'd2);
    end
    if (lstall > 0) begin
      @(posedge clk);
      #1;
      lresp_rdy = 1'b1;
      @(negedge clk);
    end
    chk("resp_no_turn", {158'd0, lresp_val, lreq_rdy}, 160'd2);
    @(negedge clk);
    chk("idle_after", {158'd0, lresp_val, lreq_rdy}, 160'd1);
    chk("drained", 160'(exp_wreq.size() + exp_lresp.size()), 160'd0);
  endtask

  initial begin : main
    int n;
    vecs[0] = '{1'b0, 32'h0000_1004, 8'h3A, 128'h0,
      128'h00000044_00000033_00000022_00000011};
    vecs[1] = '{1'b1, 32'h0000_2000, 8'h5C,
      128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA, 128'h0};
    vecs[2] = '{1'b0, 32'h0000_2008, 8'h7E, 128'h0,
      128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA};
    vecs[3] = '{1'b1, 32'h0000_3000, 8'h01,
      128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 128'h0};
    vecs[4] = '{1'b0, 32'h0000_300F, 8'hFF, 128'h0,
      128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0};
    vecs[5] = '{1'b0, 32'h0000_4000, 8'h80, 128'h0, 128'h0};

    reset = 1'b1;
    lreq_val = 1'b0;
    lreq_type = 1'b0;
    lreq_addr = '0;
    lreq_opaque = '0;
    lreq_data = '0;
    lresp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valrdy", {156'd0, lreq_rdy, lresp_val, wreq_val, wresp_rdy},
        160'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_lreq_rdy", {159'd0, lreq_rdy}, 160'd1);
    chk("rst_lresp_data", {32'd0, lresp_data}, 160'd0);

    for (int i = 0; i < 6; i++)
      do_line(vecs[i], 1'b1, 0);

    stall_word = 2'd2;
    stall_left = 3;
    do_line(vecs[0], 1'b0, 0);
    chk("stall_used", 160'(stall_left), 160'd0);

    do_line(vecs[2], 1'b0, 5);

    @(posedge clk);
    #1;
    base_push : for (int i = 0; i < 4; i++)
      exp_wreq.push_back({1'b0, 32'h1000 + 32'(4 * i), 32'h0});
    lreq_val = 1'b1;
    lreq_type = 1'b0;
    lreq_addr = 32'h0000_1000;
    lreq_opaque = 8'h55;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lreq_rdy && n < 50);
    @(posedge clk);
    #1;
    lreq_val = 1'b0;
    n = 0;
    while (exp_wreq.size() > 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("two_wreq", 160'(exp_wreq.size()), 160'd2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valrdy",
        {156'd0, lreq_rdy, lresp_val, wreq_val, wresp_rdy}, 160'd0);
    exp_wreq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_lreq_rdy", {159'd0, lreq_rdy}, 160'd1);
    chk("mid_rst_buf", {32'd0, lresp_data}, 160'd0);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (lresp_val || wreq_val) n++;
    end
    chk("mid_rst_quiet", 160'(n), 160'd0);

    do_line(vecs[0], 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lab3_mem_line_serializer.md
LAB3_MEM_LINE_SERIALIZER -- requirements
Module: lab3_mem_line_serializer

Interface
REQ-001 SHALL have parameter p_words, default 4, giving the number of 32-bit words per cache line; line width is lw = 32*p_words.
REQ-002 SHALL have port clk, input, 1 bit: clock, with all state updated on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port lreq_val / lreq_rdy, in / out, 1 bit each: line request handshake from the cache.
REQ-005 SHALL have port lreq_type, input, 1 bit: 0 = read line, 1 = write line.
REQ-006 SHALL have port lreq_addr, input, 32 bits: line address; bits [$clog2(lw/8)-1:0] are ignored.
REQ-007 SHALL have port lreq_opaque, input, 8 bits: tag returned unchanged in the response.
REQ-008 SHALL have port lreq_data, input, lw bits: write line; word i is bits [32i+31:32i].
REQ-009 SHALL have port lresp_val / lresp_rdy, out / in, 1 bit each: line response handshake.
REQ-010 SHALL have port lresp_type, output, 1 bit: the type of the request being answered.
REQ-011 SHALL have port lresp_opaque, output, 8 bits: the captured request tag.
REQ-012 SHALL have port lresp_data, output, lw bits: the assembled read line, or 0 for writes.
REQ-013 SHALL have port wreq_val / wreq_rdy, out / in, 1 bit each: word request handshake to memory.
REQ-014 SHALL have port wreq_type, output, 1 bit: 0 = read, 1 = write.
REQ-015 SHALL have port wreq_addr, output, 32 bits: word address.
REQ-016 SHALL have port wreq_data, output, 32 bits: write word.
REQ-017 SHALL have port wresp_val / wresp_rdy, in / out, 1 bit each: word response handshake from memory.
REQ-018 SHALL have port wresp_data, input, 32 bits: read word.

Function
REQ-019 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-020 SHALL assert lreq_rdy only in IDLE; on lreq_val&&lreq_rdy it SHALL capture type, opaque, data and line-aligned addr, clear the counters, and go to ISSUE.
REQ-021 SHALL, in ISSUE, assert wreq_val with wreq_addr = line_base + 4*req_cnt, wreq_type = captured type, wreq_data = word req_cnt (0 for reads); on the handshake it SHALL increment req_cnt and go to WAIT.
REQ-022 SHALL, in WAIT, assert wresp_rdy; on wresp_val, read data SHALL be stored into buffer word resp_cnt and resp_cnt SHALL increment; the FSM SHALL go to RESP if resp_cnt == p_words-1, else to ISSUE.
REQ-023 SHALL, in RESP, assert lresp_val with the captured type and opaque; lresp_data SHALL be the buffer for reads and 0 for writes; it SHALL hold stable until lresp_rdy, then go to IDLE.
REQ-024 SHALL have counters $clog2(p_words)+1 bits wide that never wrap within a transaction.
REQ-025 SHALL keep wresp_rdy at 0 outside WAIT (and outside ISSUE/WAIT when pipelined), so stray responses are never consumed.
REQ-026 SHALL have minimum latency, base mode, with single-cycle memory: accept at cycle 0, first wreq at cycle 1, lresp_val at cycle 2*p_words+1.
REQ-027 SHALL hold wreq outputs stable while wreq_val=1 and wreq_rdy=0.
REQ-028 SHALL keep lreq_rdy at 0 in RESP, including when lresp_rdy is high (no same-cycle turnaround).

Reset
REQ-029 SHALL, while reset is high, force state to IDLE, counters to 0 and buffer to 0, and drive all val/rdy outputs to 0.
REQ-030 SHALL, on the first cycle after reset, assert lreq_rdy = 1.
REQ-031 SHALL, when reset is asserted mid-transaction, abandon the transaction with no lresp produced.

Configuration
REQ-032 SHALL, when LAB3_MEM_SERIALIZER_PIPE_EN is defined, issue word requests back-to-back without waiting for responses (req_cnt < p_words); responses are accepted in order in ISSUE or WAIT, and RESP is entered when resp_cnt reaches p_words; latency with single-cycle memory becomes p_words+2.
REQ-033 SHALL, when LAB3_MEM_SERIALIZER_PIPE_EN is undefined, have exactly one word outstanding, as in REQ-021/022.

Verification
REQ-034 SHALL be verified with: read line, addr 0x00001004, opaque 0x3A, memory words 0x11,0x22,0x33,0x44 -> wreq_addr 0x1000,0x1004,0x1008,0x100C; lresp_data 0x00000044_00000033_00000022_00000011, opaque 0x3A.
REQ-035 SHALL be verified with: write line, addr 0x2000, data 0xDDDD_CCCC_BBBB_AAAA words -> four wreq, type 1, data 0xAAAA,0xBBBB,0xCCCC,0xDDDD in order; lresp type 1, data 0.
REQ-036 SHALL be verified with: wreq_rdy low 3 cycles on word 2 -> wreq_addr/wreq_data held stable; result identical to the no-stall case.
REQ-037 SHALL be verified with: lresp_rdy low 5 cycles -> lresp_val held, lreq_rdy=0 throughout; lreq_rdy=1 one cycle after acceptance.
REQ-038 SHALL be verified with: reset pulsed after the 2nd wreq -> no lresp; lreq_rdy=1 next cycle; a following read completes correctly.
REQ-039 SHALL be verified with: PIPE_EN defined, single-cycle memory -> wreq_val high 4 consecutive cycles; lresp_val at cycle 6.
